// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the unified memory port arbiter:
// access length encoding, controller state encoding and requester IDs.
package mem_arb_pkg;

   localparam logic [1:0] LEN_NONE = 2'b00;
   localparam logic [1:0] LEN_BYTE = 2'b01;
   localparam logic [1:0] LEN_HALF = 2'b10;
   localparam logic [1:0] LEN_WORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Priority decision between fetch and data: data wins unless fetch has been
// passed over STARVE_LIMIT times in a row, in which case fetch wins once.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       enable,
   input  logic       if_req,
   input  logic       d_req,
   input  logic [3:0] starve_cnt,
   output logic       grant_if,
   output logic       grant_d,
   output logic       grant_id,
   output logic [3:0] starve_next
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic starved;

   assign starved = if_req && (starve_cnt == LIMIT);

   always_comb begin
      grant_if    = 1'b0;
      grant_d     = 1'b0;
      grant_id    = REQ_IF;
      starve_next = starve_cnt;
      if (enable) begin
         if (d_req && !starved) begin
            grant_d  = 1'b1;
            grant_id = REQ_D;
            // Only a data grant that actually makes fetch wait counts toward starvation.
            if (if_req && (starve_cnt < LIMIT)) begin
               starve_next = starve_cnt + 4'd1;
            end
         end else if (if_req) begin
            grant_if    = 1'b1;
            starve_next = 4'd0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data load/store onto one memory port with a
// fixed read latency, data priority with a fetch starvation guard, and registered responses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_RD_LAT   = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic              IF_req,
   input  logic [ADDR_W-1:0] IF_addr,
   output logic              IF_ready,
   output logic              IF_rvalid,
   output logic [DATA_W-1:0] IF_rdata,
   output logic              IF_err,
   input  logic              D_req,
   input  logic              D_we,
   input  logic [ADDR_W-1:0] D_addr,
   input  logic [DATA_W-1:0] D_wdata,
   input  logic [1:0]        D_length,
   input  logic              D_signed,
   output logic              D_ready,
   output logic              D_rvalid,
   output logic [DATA_W-1:0] D_rdata,
   output logic              D_err,
   output logic              MEM_en,
   output logic              MEM_we,
   output logic [ADDR_W-1:0] MEM_addr,
   output logic [DATA_W-1:0] MEM_wdata,
   output logic [1:0]        MEM_length,
   output logic              MEM_signed,
   input  logic [DATA_W-1:0] MEM_rdata,
   output logic              busy
);

   localparam logic [2:0] WAIT_INIT = (MEM_RD_LAT > 0) ? 3'(MEM_RD_LAT - 1) : 3'd0;

   state_t            state_reg, state_next;
   logic [2:0]        wait_reg, wait_next;
   logic [3:0]        starve_reg, starve_next;
   logic              owner_reg, err_reg, store_reg;
   logic              grant_ok, grant_if, grant_d, grant_id, grant_any;
   logic              acc_err, sample;
   logic              mem_en_reg, mem_we_reg, mem_signed_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [1:0]        mem_length_reg;
   logic              if_rvalid_reg, if_err_reg, d_rvalid_reg, d_err_reg;
   logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg;

   // Readies are gated by reset so every output is low while reset is held.
   assign grant_ok  = !SYS_reset && ((state_reg == IDLE) || (state_reg == RESP));
   assign grant_any = grant_if || grant_d;
   assign acc_err   = grant_d ? (D_length == LEN_NONE) : (IF_addr[1:0] != 2'b00);

   mem_arb_select #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_select (
      .enable     (grant_ok),
      .if_req     (IF_req),
      .d_req      (D_req),
      .starve_cnt (starve_reg),
      .grant_if   (grant_if),
      .grant_d    (grant_d),
      .grant_id   (grant_id),
      .starve_next(starve_next)
   );

   always_comb begin
      state_next = state_reg;
      wait_next  = wait_reg;
      sample     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_any) state_next = ISSUE;
         end
         ISSUE: begin
            if (MEM_RD_LAT == 0) begin
               state_next = RESP;
               sample     = 1'b1;
            end else begin
               state_next = WAIT;
               wait_next  = WAIT_INIT;
            end
         end
         WAIT: begin
            if (wait_reg == 3'd0) begin
               state_next = RESP;
               sample     = 1'b1;
            end else begin
               wait_next = wait_reg - 3'd1;
            end
         end
         RESP: begin
            state_next = grant_any ? ISSUE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_reg      <= IDLE;
         wait_reg       <= 3'd0;
         starve_reg     <= 4'd0;
         owner_reg      <= REQ_IF;
         err_reg        <= 1'b0;
         store_reg      <= 1'b0;
         mem_en_reg     <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         mem_length_reg <= LEN_NONE;
         mem_signed_reg <= 1'b0;
         if_rvalid_reg  <= 1'b0;
         if_rdata_reg   <= '0;
         if_err_reg     <= 1'b0;
         d_rvalid_reg   <= 1'b0;
         d_rdata_reg    <= '0;
         d_err_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wait_reg      <= wait_next;
         starve_reg    <= starve_next;
         mem_en_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         if_rvalid_reg <= 1'b0;
         if_err_reg    <= 1'b0;
         d_rvalid_reg  <= 1'b0;
         d_err_reg     <= 1'b0;

         if (grant_any) begin
            owner_reg <= grant_id;
            err_reg   <= acc_err;
            store_reg <= grant_d && D_we;
            // Erroneous accesses never reach the memory; its address bus keeps its last value.
            if (!acc_err) begin
               mem_en_reg     <= 1'b1;
               mem_we_reg     <= grant_d && D_we;
               mem_addr_reg   <= grant_d ? D_addr : IF_addr;
               mem_length_reg <= grant_d ? D_length : LEN_WORD;
               mem_signed_reg <= grant_d && D_signed;
               if (grant_d) mem_wdata_reg <= D_wdata;
            end
         end

         if (sample) begin
            if (owner_reg == REQ_D) begin
               d_rvalid_reg <= 1'b1;
               d_err_reg    <= err_reg;
               d_rdata_reg  <= (err_reg || store_reg) ? '0 : MEM_rdata;
            end else begin
               if_rvalid_reg <= 1'b1;
               if_err_reg    <= err_reg;
               if_rdata_reg  <= err_reg ? '0 : MEM_rdata;
            end
         end
      end
   end

   assign IF_ready   = grant_if;
   assign D_ready    = grant_d;
   assign IF_rvalid  = if_rvalid_reg;
   assign IF_rdata   = if_rdata_reg;
   assign IF_err     = if_err_reg;
   assign D_rvalid   = d_rvalid_reg;
   assign D_rdata    = d_rdata_reg;
   assign D_err      = d_err_reg;
   assign MEM_en     = mem_en_reg;
   assign MEM_we     = mem_we_reg;
   assign MEM_addr   = mem_addr_reg;
   assign MEM_wdata  = mem_wdata_reg;
   assign MEM_length = mem_length_reg;
   assign MEM_signed = mem_signed_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a zero-latency instance driven from a
// vector table plus a three-cycle-latency instance for latency and reset corners.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        SYS_clk = 1'b0;
   logic        SYS_reset = 1'b1;
   logic        IF_req = 1'b0;
   logic [31:0] IF_addr = '0;
   logic        D_req = 1'b0, D_we = 1'b0, D_signed = 1'b0;
   logic [31:0] D_addr = '0, D_wdata = '0, MEM_rdata = '0;
   logic [1:0]  D_length = 2'b00;

   logic        IF_ready, IF_rvalid, IF_err, D_ready, D_rvalid, D_err;
   logic        MEM_en, MEM_we, MEM_signed, busy;
   logic [31:0] IF_rdata, D_rdata, MEM_addr, MEM_wdata;
   logic [1:0]  MEM_length;

   logic        IF_ready_3, IF_rvalid_3, IF_err_3, D_ready_3, D_rvalid_3, D_err_3;
   logic        MEM_en_3, MEM_we_3, MEM_signed_3, busy_3;
   logic [31:0] IF_rdata_3, D_rdata_3, MEM_addr_3, MEM_wdata_3;
   logic [1:0]  MEM_length_3;

   int n_checks = 0;
   int n_fail = 0;

   always #5 SYS_clk = ~SYS_clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(0), .STARVE_LIMIT(4)) dut0 (
      .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
      .IF_req(IF_req), .IF_addr(IF_addr), .IF_ready(IF_ready), .IF_rvalid(IF_rvalid),
      .IF_rdata(IF_rdata), .IF_err(IF_err),
      .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata), .D_length(D_length),
      .D_signed(D_signed), .D_ready(D_ready), .D_rvalid(D_rvalid), .D_rdata(D_rdata), .D_err(D_err),
      .MEM_en(MEM_en), .MEM_we(MEM_we), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
      .MEM_length(MEM_length), .MEM_signed(MEM_signed), .MEM_rdata(MEM_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(3), .STARVE_LIMIT(4)) dut3 (
      .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
      .IF_req(IF_req), .IF_addr(IF_addr), .IF_ready(IF_ready_3), .IF_rvalid(IF_rvalid_3),
      .IF_rdata(IF_rdata_3), .IF_err(IF_err_3),
      .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata), .D_length(D_length),
      .D_signed(D_signed), .D_ready(D_ready_3), .D_rvalid(D_rvalid_3), .D_rdata(D_rdata_3), .D_err(D_err_3),
      .MEM_en(MEM_en_3), .MEM_we(MEM_we_3), .MEM_addr(MEM_addr_3), .MEM_wdata(MEM_wdata_3),
      .MEM_length(MEM_length_3), .MEM_signed(MEM_signed_3), .MEM_rdata(MEM_rdata), .busy(busy_3)
   );

   typedef struct {
      logic [31:0] if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_length, d_signed, mem_rdata;
      logic [31:0] if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_length, mem_signed;
      logic [31:0] if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err, busy;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      int ngr;
      // Field order: if_req if_addr d_req d_we d_addr d_wdata d_length d_signed mem_rdata |
      // if_ready d_ready mem_en mem_we mem_addr mem_wdata mem_length mem_signed
      // if_rvalid if_rdata if_err d_rvalid d_rdata d_err busy
      vecs[0]  = '{1, 'h10, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 'h10, 0, 0, 0, 0, 0, 0, 'h00500613,        0, 0, 1, 0, 'h10, 0, 3, 0,                0, 0, 0, 0, 0, 0, 1};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 'h10, 0, 3, 0,                1, 'h00500613, 0, 0, 0, 0, 1};
      vecs[3]  = '{1, 'h20, 1, 0, 'h100, 0, 1, 1, 0,             0, 1, 0, 0, 'h10, 0, 3, 0,                0, 'h00500613, 0, 0, 0, 0, 0};
      vecs[4]  = '{1, 'h20, 0, 0, 0, 0, 0, 0, 'hFFFFFF80,        0, 0, 1, 0, 'h100, 0, 1, 1,               0, 'h00500613, 0, 0, 0, 0, 1};
      vecs[5]  = '{1, 'h20, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 'h100, 0, 1, 1,               0, 'h00500613, 0, 1, 'hFFFFFF80, 0, 1};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 'h12345678,           0, 0, 1, 0, 'h20, 0, 3, 0,                0, 'h00500613, 0, 0, 'hFFFFFF80, 0, 1};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 'h20, 0, 3, 0,                1, 'h12345678, 0, 0, 'hFFFFFF80, 0, 1};
      vecs[8]  = '{1, 'h12, 1, 1, 'h300, 'hDEADBEEF, 0, 0, 0,    0, 1, 0, 0, 'h20, 0, 3, 0,                0, 'h12345678, 0, 0, 'hFFFFFF80, 0, 0};
      vecs[9]  = '{1, 'h12, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 'h20, 0, 3, 0,                0, 'h12345678, 0, 0, 'hFFFFFF80, 0, 1};
      vecs[10] = '{1, 'h12, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 'h20, 0, 3, 0,                0, 'h12345678, 0, 1, 0, 1, 1};
      vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 'h20, 0, 3, 0,                0, 'h12345678, 0, 0, 0, 0, 1};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 'h20, 0, 3, 0,                1, 0, 1, 0, 0, 0, 1};
      vecs[13] = '{0, 0, 1, 1, 'h40, 'hCAFEF00D, 3, 0, 0,        0, 1, 0, 0, 'h20, 0, 3, 0,                0, 0, 0, 0, 0, 0, 0};
      vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 'hAAAAAAAA,           0, 0, 1, 1, 'h40, 'hCAFEF00D, 3, 0,       0, 0, 0, 0, 0, 0, 1};
      vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 'h40, 'hCAFEF00D, 3, 0,       0, 0, 0, 1, 0, 0, 1};
      vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 'h40, 'hCAFEF00D, 3, 0,       0, 0, 0, 0, 0, 0, 0};

      // Reset state with both requests pending: readies must stay low.
      IF_req = 1'b1;
      D_req  = 1'b1;
      @(negedge SYS_clk); #1;
      chk("rst_if_ready", IF_ready, 0);
      chk("rst_d_ready", D_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", MEM_en, 0);
      chk("rst_if_rvalid", IF_rvalid, 0);
      chk("rst_d_rvalid_3", D_rvalid_3, 0);
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      IF_req = 1'b0;
      D_req = 1'b0;

      for (int i = 0; i < 17; i++) begin
         @(negedge SYS_clk);
         IF_req    = vecs[i].if_req[0];
         IF_addr   = vecs[i].if_addr;
         D_req     = vecs[i].d_req[0];
         D_we      = vecs[i].d_we[0];
         D_addr    = vecs[i].d_addr;
         D_wdata   = vecs[i].d_wdata;
         D_length  = vecs[i].d_length[1:0];
         D_signed  = vecs[i].d_signed[0];
         MEM_rdata = vecs[i].mem_rdata;
         #1;
         $display("row %0d: if_rdy=%0d d_rdy=%0d mem_en=%0d addr=%h if_rv=%0d d_rv=%0d busy=%0d",
                  i, IF_ready, D_ready, MEM_en, MEM_addr, IF_rvalid, D_rvalid, busy);
         chk($sformatf("row%0d_if_ready", i), IF_ready, vecs[i].if_ready);
         chk($sformatf("row%0d_d_ready", i), D_ready, vecs[i].d_ready);
         chk($sformatf("row%0d_mem_en", i), MEM_en, vecs[i].mem_en);
         chk($sformatf("row%0d_mem_we", i), MEM_we, vecs[i].mem_we);
         chk($sformatf("row%0d_mem_addr", i), MEM_addr, vecs[i].mem_addr);
         chk($sformatf("row%0d_mem_wdata", i), MEM_wdata, vecs[i].mem_wdata);
         chk($sformatf("row%0d_mem_length", i), MEM_length, vecs[i].mem_length);
         chk($sformatf("row%0d_mem_signed", i), MEM_signed, vecs[i].mem_signed);
         chk($sformatf("row%0d_if_rvalid", i), IF_rvalid, vecs[i].if_rvalid);
         chk($sformatf("row%0d_if_rdata", i), IF_rdata, vecs[i].if_rdata);
         chk($sformatf("row%0d_if_err", i), IF_err, vecs[i].if_err);
         chk($sformatf("row%0d_d_rvalid", i), D_rvalid, vecs[i].d_rvalid);
         chk($sformatf("row%0d_d_rdata", i), D_rdata, vecs[i].d_rdata);
         chk($sformatf("row%0d_d_err", i), D_err, vecs[i].d_err);
         chk($sformatf("row%0d_busy", i), busy, vecs[i].busy);
      end

      // Both requesters held: expect D D D D IF D D D D IF.
      @(negedge SYS_clk);
      IF_req = 1'b1; IF_addr = 32'h4;
      D_req = 1'b1; D_we = 1'b0; D_addr = 32'h80; D_length = LEN_WORD; D_signed = 1'b0;
      MEM_rdata = 32'h0;
      ngr = 0;
      for (int c = 0; c < 40 && ngr < 10; c++) begin
         #1;
         chk("starve_one_ready", 32'(IF_ready && D_ready), 0);
         if (IF_ready || D_ready) begin
            $display("grant %0d: %s", ngr, IF_ready ? "IF" : "D");
            chk($sformatf("starve_grant%0d_is_fetch", ngr), IF_ready, 32'((ngr % 5) == 4));
            ngr++;
         end
         @(negedge SYS_clk);
      end
      chk("starve_grant_count", 32'(ngr), 10);
      IF_req = 1'b0;
      D_req = 1'b0;
      repeat (8) @(negedge SYS_clk);
      SYS_reset = 1'b1;
      @(negedge SYS_clk);
      SYS_reset = 1'b0;

      // Latency-3 load: accepted at t, response at t+5, port locked in between.
      @(negedge SYS_clk);
      D_req = 1'b1; D_we = 1'b0; D_addr = 32'h200; D_length = LEN_WORD; D_signed = 1'b0;
      MEM_rdata = 32'h11111111;
      #1;
      chk("lat3_d_ready", D_ready_3, 1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge SYS_clk);
         D_req = 1'b0;
         IF_req = 1'b1;
         IF_addr = 32'h0;
         MEM_rdata = (k == 4) ? 32'h0BADF00D : 32'h11111111 + 32'(k);
         #1;
         $display("lat3 t+%0d: rdy=%0d/%0d mem_en=%0d d_rv=%0d busy=%0d",
                  k, IF_ready_3, D_ready_3, MEM_en_3, D_rvalid_3, busy_3);
         if (k < 5) begin
            chk($sformatf("lat3_t%0d_busy", k), busy_3, 1);
            chk($sformatf("lat3_t%0d_no_ready", k), 32'(IF_ready_3 || D_ready_3), 0);
            chk($sformatf("lat3_t%0d_d_rvalid", k), D_rvalid_3, 0);
            chk($sformatf("lat3_t%0d_mem_en", k), MEM_en_3, 32'(k == 1));
         end else begin
            chk("lat3_resp_d_rvalid", D_rvalid_3, 1);
            chk("lat3_resp_d_rdata", D_rdata_3, 32'h0BADF00D);
            chk("lat3_resp_if_ready", IF_ready_3, 1);
         end
      end

      // Fetch granted above is in flight; reset it while in WAIT.
      @(negedge SYS_clk);
      IF_req = 1'b0;
      #1;
      chk("lat3_fetch_mem_en", MEM_en_3, 1);
      @(negedge SYS_clk); #1;
      chk("lat3_fetch_wait_busy", busy_3, 1);
      @(negedge SYS_clk);
      IF_req = 1'b1;
      D_req = 1'b1;
      #2 SYS_reset = 1'b1;
      #1;
      $display("async reset in WAIT: busy=%0d len=%0d d_rdata=%h", busy_3, MEM_length_3, D_rdata_3);
      chk("arst_busy", busy_3, 0);
      chk("arst_if_ready", IF_ready_3, 0);
      chk("arst_d_ready", D_ready_3, 0);
      chk("arst_mem_length", MEM_length_3, 0);
      chk("arst_d_rdata", D_rdata_3, 0);
      chk("arst_if_rvalid", IF_rvalid_3, 0);
      @(negedge SYS_clk); #1;
      chk("arst_hold_if_rvalid", IF_rvalid_3, 0);
      chk("arst_hold_busy", busy_3, 0);
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      D_req = 1'b0;
      IF_addr = 32'h0;
      #1;
      chk("post_rst_if_ready", IF_ready_3, 1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge SYS_clk);
         IF_req = 1'b0;
         MEM_rdata = (k == 4) ? 32'h00000013 : 32'h0;
         #1;
         $display("post-reset fetch t+%0d: if_rv=%0d if_rdata=%h", k, IF_rvalid_3, IF_rdata_3);
         chk($sformatf("post_rst_t%0d_if_rvalid", k), IF_rvalid_3, 32'(k == 5));
         if (k == 5) chk("post_rst_if_rdata", IF_rdata_3, 32'h00000013);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
